trace_capture: RTL and testbench

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_capture_if.sv | 11 +
 rtl/trace_capture.sv | 105 ++++++++++
 tb/tb_trace_capture.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_capture_if.sv
// Trace word stream between the capture buffer and its consumer.
// The producer holds data/valid/last until the consumer takes the word with ready.
interface trace_capture_if;
    logic [31:0] tr_data;
    logic        tr_valid;
    logic        tr_last;
    logic        tr_ready;

    modport master (output tr_data, output tr_valid, output tr_last, input tr_ready);
    modport slave  (input tr_data, input tr_valid, input tr_last, output tr_ready);
endinterface

// File: rtl/trace_capture.sv
// Processor trace capture: buffers 4-word records in a FIFO and streams them
// out one word at a time, tracking dropped records with a sticky flag and counter.
module trace_capture #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [31:0]          PC_in,
    input  logic [31:0]          Instr_in,
    input  logic [31:0]          ALUResult_in,
    input  logic                 PCSrc_in,
    input  logic                 RegWrite_in,
    input  logic                 MemWrite_in,
    input  logic [3:0]           NZCV_in,
    input  logic                 clr,
    trace_capture_if.master      tr,
    output logic [CW-1:0]        count,
    output logic                 overflow,
    output logic [7:0]           drop_count
);

    logic [3:0][31:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [1:0]       word_idx;
    logic [15:0]      timestamp;
    logic             gap_pend;

    logic             full;
    logic             accept;
    logic             pop;
    logic             push;
    logic             drop;
    logic [3:0][31:0] record;

    assign full   = (count == CW'(DEPTH));
    assign accept = tr.tr_valid && tr.tr_ready;
    assign pop    = accept && (word_idx == 2'd3);
    // A full buffer can still take a record when the head leaves on this same edge.
    assign push   = en && (!full || pop);
    assign drop   = en && full && !pop;

    assign record = {{NZCV_in, PCSrc_in, RegWrite_in, MemWrite_in, gap_pend, 8'h00, timestamp},
                     ALUResult_in, Instr_in, PC_in};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= record;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            word_idx   <= 2'd0;
            timestamp  <= 16'd0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
            gap_pend   <= 1'b0;
        end else begin
            timestamp <= timestamp + 16'd1;
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                gap_pend <= 1'b0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept) begin
                word_idx <= word_idx + 2'd1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

            // A drop on the same edge as clr counts as the first drop after clearing.
            if (drop) begin
                gap_pend   <= 1'b1;
                overflow   <= 1'b1;
                if (clr) begin
                    drop_count <= 8'd1;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end else if (clr) begin
                overflow   <= 1'b0;
                drop_count <= 8'd0;
            end
        end
    end

    always_comb begin
        tr.tr_valid = (count != '0);
        tr.tr_data  = 32'h0;
        tr.tr_last  = 1'b0;
        if (tr.tr_valid) begin
            tr.tr_data = mem[rd_ptr][word_idx];
            tr.tr_last = (word_idx == 2'd3);
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// Randomized bench for trace_capture against a queue-based record model,
// with directed scenarios whose key outputs are pinned to hand-computed values.
module tb_trace_capture;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [31:0]   pc = 32'h0;
    logic [31:0]   instr = 32'h0;
    logic [31:0]   alu = 32'h0;
    logic          pcsrc = 1'b0;
    logic          regw = 1'b0;
    logic          memw = 1'b0;
    logic [3:0]    nzcv = 4'h0;
    logic          clr = 1'b0;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    drop_count;

    trace_capture_if tif ();

    trace_capture #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .PC_in        (pc),
        .Instr_in     (instr),
        .ALUResult_in (alu),
        .PCSrc_in     (pcsrc),
        .RegWrite_in  (regw),
        .MemWrite_in  (memw),
        .NZCV_in      (nzcv),
        .clr          (clr),
        .tr           (tif),
        .count        (count),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int misc = 0;
    bit chk_on = 1'b0;

    // Reference model: queue of whole records plus the word cursor into the head.
    logic [3:0][31:0] q[$];
    int m_idx = 0;
    int m_ts = 0;
    int m_drops = 0;
    bit m_ovf = 1'b0;
    bit m_gap = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        logic [3:0][31:0] r;
        bit valid;
        bit pop;
        bit dropped;
        dropped = 1'b0;
        if (reset) begin
            q.delete();
            m_idx = 0; m_ts = 0; m_drops = 0; m_ovf = 1'b0; m_gap = 1'b0;
            return;
        end
        valid = (q.size() != 0);
        pop = valid && tif.tr_ready && (m_idx == 3);
        if (valid && tif.tr_ready) m_idx = (m_idx + 1) % 4;
        if (en) begin
            if (q.size() < DEPTH || pop) begin
                r[0] = pc;
                r[1] = instr;
                r[2] = alu;
                r[3] = {nzcv, pcsrc, regw, memw, m_gap, 8'h00, 16'(m_ts)};
                q.push_back(r);
                m_gap = 1'b0;
            end else begin
                dropped = 1'b1;
                m_gap = 1'b1;
                m_ovf = 1'b1;
                if (clr) m_drops = 1;
                else if (m_drops < 255) m_drops = m_drops + 1;
            end
        end
        if (clr && !dropped) begin
            m_ovf = 1'b0;
            m_drops = 0;
        end
        if (pop) void'(q.pop_front());
        m_ts = (m_ts + 1) % 65536;
    endtask

    task automatic compare();
        bit ev;
        logic [31:0] ed;
        ev = (q.size() != 0);
        ed = ev ? q[0][m_idx] : 32'h0;
        chk("tr_valid", 32'(tif.tr_valid), 32'(ev));
        chk("tr_data", tif.tr_data, ed);
        chk("tr_last", 32'(tif.tr_last), 32'(ev && (m_idx == 3)));
        chk("count", 32'(count), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), 32'(m_drops));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) compare();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        pc = $urandom; instr = $urandom; alu = $urandom;
        pcsrc = 1'($urandom); regw = 1'($urandom); memw = 1'($urandom);
        nzcv = 4'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; clr = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    int en_th;
    int rdy_th;

    initial begin
        tif.tr_ready = 1'b0;

        // Single capture: idle cycle after reset so the record carries timestamp 1.
        do_reset();
        chk_on = 1'b1;
        tick();
        en = 1'b1; pc = 32'h8; instr = 32'hE2811001; alu = 32'h5; nzcv = 4'b0100;
        regw = 1'b1; pcsrc = 1'b0; memw = 1'b0; tif.tr_ready = 1'b1;
        tick();
        en = 1'b0;
        @(negedge clk); chk("single_w0", tif.tr_data, 32'h8); chk("single_last0", 32'(tif.tr_last), 32'h0);
        tick();
        @(negedge clk); chk("single_w1", tif.tr_data, 32'hE2811001);
        tick();
        @(negedge clk); chk("single_w2", tif.tr_data, 32'h5); chk("single_last2", 32'(tif.tr_last), 32'h0);
        tick();
        @(negedge clk); chk("single_w3", tif.tr_data, 32'h44000001); chk("single_last3", 32'(tif.tr_last), 32'h1);
        tick();
        @(negedge clk); chk("single_empty_valid", 32'(tif.tr_valid), 32'h0); chk("single_empty_count", 32'(count), 32'h0);

        // Backpressure: head word must hold while the consumer stalls.
        do_reset();
        tif.tr_ready = 1'b0;
        en = 1'b1; pc = 32'hCAFE_0010;
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_data", tif.tr_data, 32'hCAFE_0010);
            chk("bp_valid", 32'(tif.tr_valid), 32'h1);
            tick();
        end
        tif.tr_ready = 1'b1;
        repeat (4) tick();

        // Overflow and gap marker on the first record after the drops.
        do_reset();
        tif.tr_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 11; i++) begin rand_inputs(); tick(); end
        en = 1'b0;
        @(negedge clk);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_drops", 32'(drop_count), 32'd3);
        tif.tr_ready = 1'b1;
        repeat (32) tick();
        @(negedge clk); chk("ovf_drained", 32'(count), 32'd0);
        en = 1'b1; rand_inputs();
        tick();
        en = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("gap_last", 32'(tif.tr_last), 32'h1);
        chk("gap_bit", 32'(tif.tr_data[24]), 32'h1);
        tick();

        // Full buffer with the head popping on the same edge as a new capture.
        do_reset();
        tif.tr_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin rand_inputs(); tick(); end
        en = 1'b0; tif.tr_ready = 1'b1;
        repeat (3) tick();
        en = 1'b1; rand_inputs();
        tick();
        en = 1'b0; tif.tr_ready = 1'b0;
        @(negedge clk);
        chk("fullpop_count", 32'(count), 32'd8);
        chk("fullpop_drops", 32'(drop_count), 32'd0);
        chk("fullpop_ovf", 32'(overflow), 32'h0);

        // Saturation, clear, and clear colliding with a drop.
        do_reset();
        tif.tr_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 308; i++) begin rand_inputs(); tick(); end
        en = 1'b0;
        @(negedge clk);
        chk("sat_drops", 32'(drop_count), 32'd255);
        chk("sat_ovf", 32'(overflow), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_drops", 32'(drop_count), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'h0);
        clr = 1'b1; en = 1'b1;
        tick();
        clr = 1'b0; en = 1'b0;
        @(negedge clk);
        chk("clrdrop_drops", 32'(drop_count), 32'd1);
        chk("clrdrop_ovf", 32'(overflow), 32'h1);

        // Reset after two words of a record went out.
        do_reset();
        tick();
        en = 1'b1; rand_inputs();
        tick();
        en = 1'b0; tif.tr_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; tif.tr_ready = 1'b0;
        @(negedge clk);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(tif.tr_valid), 32'h0);
        tick();
        en = 1'b1; pc = 32'h100; instr = 32'h0; alu = 32'h0; nzcv = 4'h0;
        pcsrc = 1'b0; regw = 1'b0; memw = 1'b0;
        tick();
        en = 1'b0;
        @(negedge clk); chk("midrst_w0", tif.tr_data, 32'h100);
        tif.tr_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk); chk("midrst_w3", tif.tr_data, 32'h00000001);
        tick();

        // Randomized traffic with load phases that swing between empty and full.
        for (int i = 0; i < 3000; i++) begin
            en_th = ((i / 200) % 2 == 0) ? 8 : 3;
            case ((i / 200) % 3)
                0: rdy_th = 1;
                1: rdy_th = 5;
                default: rdy_th = 9;
            endcase
            reset = ($urandom_range(0, 399) == 0);
            clr = ($urandom_range(0, 49) == 0);
            en = ($urandom_range(0, 9) < en_th);
            tif.tr_ready = ($urandom_range(0, 9) < rdy_th);
            rand_inputs();
            tick();
        end
        reset = 1'b0; en = 1'b0; clr = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule
